icache: RTL and testbench



---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_way_ram.sv | 24 ++
 rtl/icache.sv | 203 ++++++++++++++++++++
 tb/tb_icache.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache shared types and constants.
// The op encoding is shared with Fetch1.
package icache_pkg;

  localparam int ICACHE_SETS       = 256;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_WAYS       = 2;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_READ     = 3'd1,
    OP_IDX_INIT = 3'd2,
    OP_IDX_INV  = 3'd3,
    OP_HIT_INV  = 3'd4
  } icache_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_RESPOND
  } icache_state_t;

endpackage

// File: rtl/icache_way_ram.sv
// One icache way: tag + 16-byte line per set.
// 1-cycle read; output holds while en is low.
module icache_way_ram
  import icache_pkg::*;
(
  input  logic         clk,
  input  logic         en,
  input  logic         we,
  input  logic [7:0]   addr,
  input  logic [19:0]  wtag,
  input  logic [127:0] wline,
  output logic [19:0]  rtag,
  output logic [127:0] rline
);

  logic [147:0] mem [ICACHE_SETS];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= {wtag, wline};
    if (en) {rtag, rline} <= mem[addr];
  end

endmodule

// File: rtl/icache.sv
// Two-way blocking instruction cache.
// Fetch1 request in, one word out to Fetch2.
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic        icache_is_cached,
  input  logic [31:0] icache_pa,
  output logic        icache_ready,
  output logic [31:0] icache_data,
  output logic        icache_data_valid,
  input  logic        icache_data_ready,
  output logic        inst_rd_req,
  output logic [2:0]  inst_rd_type,
  output logic [31:0] inst_rd_addr,
  input  logic        inst_rd_rdy,
  input  logic        inst_ret_valid,
  input  logic        inst_ret_last,
  input  logic [31:0] inst_ret_data
);

  icache_state_t state;
  icache_op_t    op_q;
  logic [31:0]   pa_q;
  logic          cached_q;
  logic [7:0]    set_q;
  logic [1:0]    cnt;

  logic [1:0][ICACHE_SETS-1:0] vld;
  logic [ICACHE_SETS-1:0]      lru;
  logic [3:0][31:0]            rbuf;

  logic [19:0]  rtag  [ICACHE_WAYS];
  logic [127:0] rline [ICACHE_WAYS];

  logic [1:0]       way_we;
  logic             ram_en;
  logic [7:0]       ram_addr;
  logic [19:0]      wtag;
  logic [127:0]     wline;
  logic [1:0]       hit;
  logic             hit_way;
  logic             rd_hit;
  logic             accept;
  logic             fill_done;
  logic             idx_init;
  logic             victim;
  logic [3:0][31:0] fill_line;
  logic [31:0]      hit_word;
  logic [1:0]       rsp_sel;
  logic             unused_idx;

  assign unused_idx = ^icache_idx[3:0];

  assign hit[0] = vld[0][set_q]
               && rtag[0] == pa_q[31:12];
  assign hit[1] = vld[1][set_q]
               && rtag[1] == pa_q[31:12];
  assign hit_way = !hit[0];

  assign rd_hit = state == S_LOOKUP
               && op_q == OP_READ
               && cached_q && |hit;

  assign icache_ready = state == S_IDLE
                     || (rd_hit && icache_data_ready);
  assign accept = icache_ready
               && icache_op != OP_NOP;

  assign ram_en   = accept;
  assign ram_addr = accept ? icache_idx[11:4] : set_q;

  assign hit_word =
    rline[hit_way][{pa_q[3:2], 5'b0} +: 32];
  assign rsp_sel = cached_q ? pa_q[3:2] : 2'd0;

  assign icache_data_valid = rd_hit
                          || state == S_RESPOND;
  assign icache_data = state == S_RESPOND
                     ? rbuf[rsp_sel] : hit_word;

  assign inst_rd_req  = state == S_MISS;
  assign inst_rd_type = cached_q ? RD_TYPE_LINE
                                 : RD_TYPE_WORD;
  assign inst_rd_addr = cached_q ? {pa_q[31:4], 4'b0}
                                 : pa_q;

  assign fill_done = state == S_REFILL
                  && inst_ret_valid && inst_ret_last;
  assign idx_init  = state == S_LOOKUP
                  && op_q == OP_IDX_INIT;

  // Victim: invalid way 0, then invalid way 1, else LRU
  always_comb begin
    victim = lru[set_q];
    if (!vld[0][set_q])      victim = 1'b0;
    else if (!vld[1][set_q]) victim = 1'b1;
  end

  // Line image including the final beat in flight
  always_comb begin
    fill_line      = rbuf;
    fill_line[cnt] = inst_ret_data;
  end

  assign way_we[0] = (fill_done && cached_q && !victim)
                  || (idx_init && !pa_q[0]);
  assign way_we[1] = (fill_done && cached_q && victim)
                  || (idx_init && pa_q[0]);
  assign wtag  = idx_init ? 20'd0  : pa_q[31:12];
  assign wline = idx_init ? 128'd0 : fill_line;

  for (genvar w = 0; w < ICACHE_WAYS; w++) begin : g_way
    icache_way_ram u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (way_we[w]),
      .addr  (ram_addr),
      .wtag  (wtag),
      .wline (wline),
      .rtag  (rtag[w]),
      .rline (rline[w])
    );
  end

  // Control FSM with valid, LRU and refill buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      pa_q     <= '0;
      cached_q <= 1'b0;
      set_q    <= '0;
      cnt      <= '0;
      vld      <= '0;
      lru      <= '0;
      rbuf     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_LOOKUP: begin
          case (op_q)
            OP_READ: begin
              if (!cached_q) begin
                state <= S_MISS;
              end else if (|hit) begin
                if (icache_data_ready) begin
                  lru[set_q] <= ~hit_way;
                  state      <= S_IDLE;
                end
              end else begin
                state <= S_MISS;
              end
            end
            OP_IDX_INIT, OP_IDX_INV: begin
              vld[pa_q[0]][set_q] <= 1'b0;
              state <= S_IDLE;
            end
            OP_HIT_INV: begin
              if (hit[0]) vld[0][set_q] <= 1'b0;
              if (hit[1]) vld[1][set_q] <= 1'b0;
              state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_MISS: begin
          if (inst_rd_rdy) state <= S_REFILL;
        end
        S_REFILL: begin
          if (inst_ret_valid) begin
            rbuf[cnt] <= inst_ret_data;
            cnt       <= cnt + 2'd1;
            if (inst_ret_last) begin
              cnt   <= '0;
              state <= S_RESPOND;
              if (cached_q) begin
                vld[victim][set_q] <= 1'b1;
                lru[set_q]         <= ~victim;
              end
            end
          end
        end
        S_RESPOND: begin
          if (icache_data_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (accept) begin
        op_q     <= icache_op_t'(icache_op);
        pa_q     <= icache_pa;
        cached_q <= icache_is_cached;
        set_q    <= icache_idx[11:4];
        state    <= S_LOOKUP;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache with a bridge model
// and a way/LRU reference model.
module tb_icache;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] icache_idx = '0;
  logic [2:0]  icache_op = 3'd0;
  logic        icache_is_cached = 1'b1;
  logic [31:0] icache_pa = '0;
  logic        icache_ready;
  logic [31:0] icache_data;
  logic        icache_data_valid;
  logic        icache_data_ready = 1'b1;
  logic        inst_rd_req;
  logic [2:0]  inst_rd_type;
  logic [31:0] inst_rd_addr;
  logic        inst_rd_rdy = 1'b0;
  logic        inst_ret_valid = 1'b0;
  logic        inst_ret_last = 1'b0;
  logic [31:0] inst_ret_data = '0;

  icache dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .icache_idx        (icache_idx),
    .icache_op         (icache_op),
    .icache_is_cached  (icache_is_cached),
    .icache_pa         (icache_pa),
    .icache_ready      (icache_ready),
    .icache_data       (icache_data),
    .icache_data_valid (icache_data_valid),
    .icache_data_ready (icache_data_ready),
    .inst_rd_req       (inst_rd_req),
    .inst_rd_type      (inst_rd_type),
    .inst_rd_addr      (inst_rd_addr),
    .inst_rd_rdy       (inst_rd_rdy),
    .inst_ret_valid    (inst_ret_valid),
    .inst_ret_last     (inst_ret_last),
    .inst_ret_data     (inst_ret_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_data [$];
  logic [63:0] exp_req [$];
  int          pop_cyc [$];
  int          last_pop = 0;

  logic [31:0] mem [logic [31:0]];

  bit          mv [2][256];
  logic [19:0] mt [2][256];
  bit          ml [256];

  bit   dr_rand = 1'b0;
  logic dr_val  = 1'b1;

  int          req_cyc = 0;
  int          last_cyc = 0;
  int          beats = 0;
  bit          busy = 1'b0;
  logic [31:0] ba = '0;
  logic [2:0]  bt = '0;
  int          bn = 0;
  int          acc_cyc = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected",
             name);
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Reference model: update on acceptance
  task automatic model(input logic [2:0] op,
                       input logic [31:0] pa,
                       input bit c);
    int s;
    int hw;
    int v;
    logic [19:0] tg;
    s  = int'(pa[11:4]);
    tg = pa[31:12];
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (mv[w][s] && mt[w][s] == tg) hw = w;
    case (op)
      OP_READ: begin
        exp_data.push_back({32'd0, mem_word(pa)});
        if (!c) begin
          exp_req.push_back({29'd0, RD_TYPE_WORD, pa});
        end else if (hw >= 0) begin
          ml[s] = (hw == 0);
        end else begin
          if (!mv[0][s])      v = 0;
          else if (!mv[1][s]) v = 1;
          else                v = ml[s] ? 1 : 0;
          mv[v][s] = 1'b1;
          mt[v][s] = tg;
          ml[s]    = (v == 0);
          exp_req.push_back({29'd0, RD_TYPE_LINE,
                             pa[31:4], 4'b0});
        end
      end
      OP_IDX_INIT: begin
        mv[pa[0]][s] = 1'b0;
        mt[pa[0]][s] = '0;
      end
      OP_IDX_INV: mv[pa[0]][s] = 1'b0;
      OP_HIT_INV: if (hw >= 0) mv[hw][s] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int s = 0; s < 256; s++) begin
      mv[0][s] = 1'b0;
      mv[1][s] = 1'b0;
      ml[s]    = 1'b0;
    end
  endtask

  // Issue one request; call at posedge+1
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] pa,
                       input bit c);
    int n;
    n = 0;
    icache_op        = op;
    icache_pa        = pa;
    icache_idx       = pa[11:0];
    icache_is_cached = c;
    @(negedge clk);
    while (!icache_ready) begin
      n++;
      if (n > 500) begin
        fail_now("accept_timeout");
        finish_run();
      end
      @(negedge clk);
    end
    acc_cyc = cyc;
    model(op, pa, c);
    @(posedge clk);
    #1;
    icache_op = 3'd0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_data.size() != 0 || busy)
           && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      fail_now({name, "_drain_timeout"});
      finish_run();
    end
    check({name, "_reqs_left"}, exp_req.size(), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch2 ready driver
  always @(posedge clk) begin
    #2;
    icache_data_ready = dr_rand
      ? ($urandom_range(0, 3) != 0) : dr_val;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && icache_data_valid
        && icache_data_ready) begin
      if (exp_data.size() == 0) begin
        fail_now("unexpected_data");
      end else begin
        check("data", {32'd0, icache_data},
              exp_data.pop_front());
        pop_cyc.push_back(cyc);
        last_pop = cyc;
      end
    end
  end

  // Bridge model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && inst_rd_req) begin
        busy    = 1'b1;
        req_cyc = cyc;
        repeat ($urandom_range(0, 2)) step();
        ba = inst_rd_addr;
        bt = inst_rd_type;
        if (exp_req.size() == 0)
          fail_now("unexpected_req");
        else
          check("req", {29'd0, bt, ba},
                exp_req.pop_front());
        inst_rd_rdy = 1'b1;
        step();
        inst_rd_rdy = 1'b0;
        bn = (bt == RD_TYPE_LINE) ? 4 : 1;
        for (int i = 0; i < bn; i++) begin
          repeat ($urandom_range(0, 1)) step();
          inst_ret_valid = 1'b1;
          inst_ret_data  = mem_word(ba + 32'(4 * i));
          inst_ret_last  = (i == bn - 1);
          last_cyc = cyc;
          beats++;
          step();
          inst_ret_valid = 1'b0;
          inst_ret_last  = 1'b0;
        end
        busy = 1'b0;
      end
    end
  end

  int acc [4];
  int b0;
  int n;
  logic [31:0] pa;
  logic [2:0]  op;
  int r;

  initial begin
    model_reset();
    mem[32'h1C000000] = 32'h11;
    mem[32'h1C000004] = 32'h22;
    mem[32'h1C000008] = 32'h33;
    mem[32'h1C00000C] = 32'h44;
    mem[32'h1FD00010] = 32'hDEAD;

    repeat (3) @(negedge clk);
    check("rst_ready", icache_ready, 1);
    check("rst_valid", icache_data_valid, 0);
    check("rst_req", inst_rd_req, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", icache_ready, 1);
    check("rel_valid", icache_data_valid, 0);
    check("rel_req", inst_rd_req, 0);
    step();

    issue(OP_READ, 32'h1C000004, 1);
    b0 = acc_cyc;
    drain("cold");
    check("cold_addr", ba, 32'h1C000000);
    check("cold_type", bt, RD_TYPE_LINE);
    check("miss_req_cyc", req_cyc, b0 + 2);
    check("miss_rsp_cyc", last_pop, last_cyc + 1);

    issue(OP_READ, 32'h1C000004, 1);
    drain("hit");
    check("hit_latency", last_pop, acc_cyc + 1);

    pop_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      issue(OP_READ, 32'h1C000000 + 32'(4 * i), 1);
      acc[i] = acc_cyc;
    end
    drain("b2b");
    check("b2b_count", pop_cyc.size(), 4);
    for (int i = 1; i < 4; i++) begin
      check("b2b_acc", acc[i], acc[0] + i);
      if (pop_cyc.size() == 4)
        check("b2b_pop", pop_cyc[i], pop_cyc[0] + i);
    end

    issue(OP_READ, 32'h1C001000, 1);
    issue(OP_READ, 32'h1C002000, 1);
    issue(OP_READ, 32'h1C000000, 1);
    drain("evict");

    issue(OP_READ, 32'h1FD00010, 0);
    drain("unc1");
    check("unc_addr", ba, 32'h1FD00010);
    check("unc_type", bt, RD_TYPE_WORD);
    issue(OP_READ, 32'h1FD00010, 0);
    drain("unc2");

    issue(OP_HIT_INV, 32'h1C002000, 1);
    issue(OP_READ, 32'h1C002000, 1);
    drain("hitinv");
    issue(OP_IDX_INV, 32'h1C000001, 1);
    issue(OP_READ, 32'h1C002000, 1);
    issue(OP_READ, 32'h1C000000, 1);
    drain("idxinv");

    dr_val = 1'b0;
    issue(OP_READ, 32'h1C002008, 1);
    icache_op  = OP_READ;
    icache_pa  = 32'h1C000004;
    icache_idx = 12'h004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", icache_data_valid, 1);
      check("stall_data", icache_data,
            mem_word(32'h1C002008));
      check("stall_ready", icache_ready, 0);
    end
    step();
    icache_op = 3'd0;
    dr_val = 1'b1;
    drain("stall");

    b0 = beats;
    issue(OP_READ, 32'h1C003000, 1);
    n = 0;
    while (beats < b0 + 2 && n < 200) begin
      step();
      n++;
    end
    check("rst_reached_refill", beats >= b0 + 2, 1);
    rst_n = 1'b0;
    exp_data.delete();
    repeat (3) @(negedge clk);
    check("mid_rst_ready", icache_ready, 1);
    check("mid_rst_valid", icache_data_valid, 0);
    check("mid_rst_req", inst_rd_req, 0);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    issue(OP_READ, 32'h1C002000, 1);
    issue(OP_READ, 32'h1C000004, 1);
    issue(OP_READ, 32'h1C003000, 1);
    drain("post_rst");

    dr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 9));
      pa = {20'h1C000 + 20'($urandom_range(0, 3)),
            8'($urandom_range(0, 3)) ^ 8'hFC,
            2'($urandom_range(0, 3)), 2'b00};
      if (r < 7) begin
        issue(OP_READ, pa, 1);
      end else if (r == 7) begin
        issue(OP_READ,
              32'h1FD00000 | {$urandom_range(0, 63), 2'b00},
              0);
      end else begin
        op = 3'(2 + $urandom_range(0, 2));
        issue(op, pa | 32'($urandom_range(0, 1)), 1);
      end
      repeat ($urandom_range(0, 1)) step();
    end
    drain("random");
    check("final_data_left", exp_data.size(), 0);

    finish_run();
  end

endmodule
